// File: rtl/matvec_engine.sv
// matvec_engine: computes C = A * B for a ROWS x COLS matrix A and a COLS-element
// vector B, both fetched from an Avalon-MM memory (one memory word per vector/row).
// Word base holds B; word base+1+r holds row r of A. ROWS MAC lanes then run in
// parallel for COLS cycles.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, base_addr    one-cycle start request and word address of B
//   mem_address/read    Avalon-MM read request (word address), registered
//   mem_readdata        COLS elements, element j at [j*DATA_WIDTH +: DATA_WIDTH]
//   mem_readdatavalid   read data valid this cycle
//   mem_waitrequest     slave stalls the current request
//   busy                high while fetching or computing
//   done                high once the result is valid, until the next start
//   result              ROWS accumulators, C[r] at [r*ACC_WIDTH +: ACC_WIDTH]
module matvec_engine #(
  parameter int DATA_WIDTH  = 8,
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int ACC_WIDTH   = 24,
  parameter int SIGNED_MODE = 0,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        base_addr,
  output logic [ADDR_WIDTH-1:0]        mem_address,
  output logic                         mem_read,
  input  logic [COLS*DATA_WIDTH-1:0]   mem_readdata,
  input  logic                         mem_readdatavalid,
  input  logic                         mem_waitrequest,
  output logic                         busy,
  output logic                         done,
  output logic [ROWS*ACC_WIDTH-1:0]    result
);

  localparam int IDX_W = $clog2(ROWS + 2);
  localparam int K_W   = $clog2(COLS + 1);
  localparam int EXT_W = (ACC_WIDTH > 2 * DATA_WIDTH) ? ACC_WIDTH : 2 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, FETCH, COMPUTE, DONE} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   base;
  logic [IDX_W-1:0]        index;
  logic                    pending;
  logic [K_W-1:0]          k;
  logic [DATA_WIDTH-1:0]   b_buf [COLS];
  logic [DATA_WIDTH-1:0]   a_buf [ROWS][COLS];
  logic [ACC_WIDTH-1:0]    acc   [ROWS];
  logic [DATA_WIDTH-1:0]   b_col;
  logic [DATA_WIDTH-1:0]   a_col [ROWS];
  logic                    start_ok, word_in, last_word;

  assign start_ok  = start && (state == IDLE || state == DONE);
  // Data is only taken while a read is actually outstanding in FETCH.
  assign word_in   = (state == FETCH) && pending && mem_readdatavalid;
  assign last_word = word_in && (index == IDX_W'(ROWS));

  // Product at 2*DATA_WIDTH, then sign/zero-extended (or truncated) to ACC_WIDTH.
  function automatic logic [ACC_WIDTH-1:0] mac_term(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    logic [2*DATA_WIDTH-1:0] p;
    logic [EXT_W-1:0]        wide;
    if (SIGNED_MODE != 0) begin
      p    = $signed({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a}) *
             $signed({{DATA_WIDTH{b[DATA_WIDTH-1]}}, b});
      wide = EXT_W'($signed(p));
    end else begin
      p    = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
      wide = EXT_W'(p);
    end
    return wide[ACC_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start)                   state_next = FETCH;
      FETCH:      if (last_word)               state_next = COMPUTE;
      COMPUTE:    if (k == K_W'(COLS - 1))     state_next = DONE;
      default:                                 state_next = IDLE;
    endcase
  end

  // Column k of A and element k of B feeding the lanes this COMPUTE cycle.
  always_comb begin
    b_col = '0;
    for (int unsigned r = 0; r < ROWS; r++) a_col[r] = '0;
    for (int unsigned j = 0; j < COLS; j++) begin
      if (k == K_W'(j)) begin
        b_col = b_buf[j];
        for (int unsigned r = 0; r < ROWS; r++) a_col[r] = a_buf[r][j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base        <= '0;
      index       <= '0;
      pending     <= 1'b0;
      k           <= '0;
      mem_read    <= 1'b0;
      mem_address <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      for (int unsigned j = 0; j < COLS; j++) b_buf[j] <= '0;
      for (int unsigned r = 0; r < ROWS; r++) begin
        acc[r] <= '0;
        for (int unsigned j = 0; j < COLS; j++) a_buf[r][j] <= '0;
      end
    end else begin
      busy <= (state_next == FETCH) || (state_next == COMPUTE);
      done <= (state_next == DONE);
      if (start_ok) begin
        base        <= base_addr;
        index       <= '0;
        pending     <= 1'b0;
        k           <= '0;
        mem_read    <= 1'b1;
        mem_address <= base_addr;
        for (int unsigned r = 0; r < ROWS; r++) acc[r] <= '0;
      end else begin
        case (state)
          FETCH: begin
            if (mem_read && !mem_waitrequest) begin
              mem_read <= 1'b0;
              pending  <= 1'b1;
            end
            if (word_in) begin
              pending <= 1'b0;
              index   <= index + IDX_W'(1);
              if (index == '0) begin
                for (int unsigned j = 0; j < COLS; j++)
                  b_buf[j] <= mem_readdata[j*DATA_WIDTH +: DATA_WIDTH];
              end
              for (int unsigned r = 0; r < ROWS; r++) begin
                if (index == IDX_W'(r + 1)) begin
                  for (int unsigned j = 0; j < COLS; j++)
                    a_buf[r][j] <= mem_readdata[j*DATA_WIDTH +: DATA_WIDTH];
                end
              end
              if (!last_word) begin
                mem_read    <= 1'b1;
                mem_address <= base + ADDR_WIDTH'(index) + ADDR_WIDTH'(1);
              end
            end
          end
          COMPUTE: begin
            k <= k + K_W'(1);
            for (int unsigned r = 0; r < ROWS; r++)
              acc[r] <= acc[r] + mac_term(a_col[r], b_col);
          end
          default: ;
        endcase
      end
    end
  end

  // Accumulators are flops and are cleared on start, so they double as the result.
  always_comb begin
    result = '0;
    for (int unsigned r = 0; r < ROWS; r++) result[r*ACC_WIDTH +: ACC_WIDTH] = acc[r];
  end

endmodule

// File: tb/tb_matvec_engine.sv
// tb_matvec_engine: directed and random runs of matvec_engine against an
// arithmetic reference model. Three instances share one memory model: default
// parameters, SIGNED_MODE=1, and ACC_WIDTH=8.
module tb_matvec_engine;
  localparam int DW = 8;
  localparam int R  = 8;
  localparam int C  = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [31:0]     base_addr = '0;
  logic [C*DW-1:0] mem_readdata = '0;
  logic            mem_readdatavalid = 1'b0;
  logic            mem_waitrequest = 1'b0;
  logic [31:0]     mem_address, addr_s, addr_8;
  logic            mem_read, rd_s, rd_8;
  logic            busy, busy_s, busy_8, done, done_s, done_8;
  logic [R*24-1:0] res_u, res_s;
  logic [R*8-1:0]  res_8;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [C*DW-1:0] mem [logic [31:0]];
  logic [31:0]     acc_log [$];
  int              n_valid = 0, last_valid_cyc = 0, stall_cycles = 0, stall_bad = 0;
  logic [31:0]     stall_addr = '1;
  int              stall_len = 0, stall_gen = 0, inj_gen = 0;

  bit              pend = 1'b0, hold_chk = 1'b0;
  logic [31:0]     pend_addr = '0, held_addr = '0;
  int              stall_left = 0, stall_seen = 0, inj_seen = 0;

  matvec_engine u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .mem_address(mem_address), .mem_read(mem_read), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid), .mem_waitrequest(mem_waitrequest),
    .busy(busy), .done(done), .result(res_u));

  matvec_engine #(.SIGNED_MODE(1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .mem_address(addr_s), .mem_read(rd_s), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid), .mem_waitrequest(mem_waitrequest),
    .busy(busy_s), .done(done_s), .result(res_s));

  matvec_engine #(.ACC_WIDTH(8)) u_acc8 (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .mem_address(addr_8), .mem_read(rd_8), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid), .mem_waitrequest(mem_waitrequest),
    .busy(busy_8), .done(done_8), .result(res_8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Avalon-MM slave: accepts a read when mem_read && !mem_waitrequest at an edge
  // and returns the word in the following cycle. Optional stall on one address,
  // optional stray readdatavalid injection.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0; hold_chk = 1'b0;
        mem_readdatavalid = 1'b0; mem_waitrequest = 1'b0;
        continue;
      end
      mem_readdatavalid = pend;
      if (pend) begin
        mem_readdata   = mem.exists(pend_addr) ? mem[pend_addr] : '0;
        n_valid++;
        last_valid_cyc = cyc;
      end else if (inj_gen != inj_seen) begin
        inj_seen          = inj_gen;
        mem_readdatavalid = 1'b1;
        mem_readdata      = {C{8'hA5}};
      end
      pend = 1'b0;
      if (stall_gen != stall_seen) begin
        stall_seen = stall_gen;
        stall_left = stall_len;
      end
      if (hold_chk) begin
        if (!mem_read || mem_address != held_addr) stall_bad++;
        hold_chk = 1'b0;
      end
      if (mem_read && mem_address == stall_addr && stall_left > 0) begin
        mem_waitrequest = 1'b1;
        stall_left--;
        stall_cycles++;
        hold_chk  = 1'b1;
        held_addr = mem_address;
      end else begin
        mem_waitrequest = 1'b0;
        if (mem_read) begin
          pend      = 1'b1;
          pend_addr = mem_address;
          acc_log.push_back(mem_address);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind 0: B=1, A[r][k]=r+1; 1: A=0xFF, B=0x02; 2: all 0xFF; else random.
  task automatic load(input logic [31:0] b, input int kind);
    for (int w = 0; w <= R; w++) begin
      logic [C*DW-1:0] word;
      word = '0;
      for (int j = 0; j < C; j++) begin
        logic [7:0] e;
        case (kind)
          0:       e = (w == 0) ? 8'd1 : 8'(w);
          1:       e = (w == 0) ? 8'h02 : 8'hFF;
          2:       e = 8'hFF;
          default: e = 8'($urandom);
        endcase
        word[j*8 +: 8] = e;
      end
      mem[b + 32'(w)] = word;
    end
  endtask

  // C[r] = sum_k A[r][k]*B[k], taken modulo 2^aw.
  function automatic logic [63:0] model(input logic [31:0] b, input int r, input bit sgn,
                                        input int aw);
    logic [C*DW-1:0] bw, aw_row;
    longint s;
    bw = mem[b];
    aw_row = mem[b + 32'(1 + r)];
    s = 0;
    for (int k = 0; k < C; k++) begin
      logic [7:0] x, y;
      x = aw_row[k*8 +: 8];
      y = bw[k*8 +: 8];
      if (sgn) s += longint'($signed(x)) * longint'($signed(y));
      else     s += longint'(x) * longint'(y);
    end
    return 64'(s) & ((64'd1 << aw) - 64'd1);
  endfunction

  task automatic check_results(input string tag, input logic [31:0] b);
    chk({tag, "_done_s"}, done_s, 1'b1);
    chk({tag, "_done_8"}, done_8, 1'b1);
    for (int r = 0; r < R; r++) begin
      chk({tag, "_cu"}, res_u[r*24 +: 24], model(b, r, 1'b0, 24));
      chk({tag, "_cs"}, res_s[r*24 +: 24], model(b, r, 1'b1, 24));
      chk({tag, "_c8"}, res_8[r*8 +: 8],   model(b, r, 1'b0, 8));
    end
  endtask

  task automatic do_start(input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int t);
    t = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk("done_timeout", done, 1'b1);
  endtask

  task automatic check_reads(input string tag, input int a0, input logic [31:0] b);
    chk({tag, "_nreads"}, acc_log.size() - a0, R + 1);
    for (int i = 0; i <= R && a0 + i < acc_log.size(); i++)
      chk({tag, "_addr"}, acc_log[a0 + i], b + 32'(i));
  endtask

  initial begin
    int a0, v0, s0, b0, t;

    // Reset state
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_read", mem_read, 1'b0);
    chk("rst_addr", mem_address, 32'h0);
    chk("rst_res", res_u, '0);
    #2 rst_n = 1'b1;

    // Directed data, zero-wait memory; done rises on the COLS-th edge after the
    // edge that samples the last readdatavalid.
    load(32'h10, 0);
    a0 = acc_log.size();
    do_start(32'h10);
    wait_done(t);
    check_reads("a", a0, 32'h10);
    chk("a_latency", t, last_valid_cyc + C + 1);
    for (int r = 0; r < R; r++) chk("a_lit", res_u[r*24 +: 24], 8 * (r + 1));
    check_results("a", 32'h10);

    // Three-cycle waitrequest on word 0x13
    stall_addr = 32'h13; stall_len = 3; stall_gen++;
    s0 = stall_cycles; b0 = stall_bad; a0 = acc_log.size();
    do_start(32'h10);
    wait_done(t);
    chk("b_stall_cycles", stall_cycles - s0, 3);
    chk("b_stall_stable", stall_bad - b0, 0);
    check_reads("b", a0, 32'h10);
    for (int r = 0; r < R; r++) chk("b_lit", res_u[r*24 +: 24], 8 * (r + 1));
    stall_len = 0; stall_gen++;

    // A=0xFF, B=0x02: unsigned 4080, signed -16, 8-bit accumulator 0xF0
    load(32'h20, 1);
    do_start(32'h20);
    wait_done(t);
    chk("c_unsigned", res_u[23:0], 24'd4080);
    chk("c_signed", res_s[23:0], 24'hFFFFF0);
    chk("c_acc8", res_8[7:0], 8'hF0);
    check_results("c", 32'h20);

    // Random data, start pulsed mid-FETCH and mid-COMPUTE
    load(32'h30, 3);
    a0 = acc_log.size(); v0 = n_valid;
    do_start(32'h30);
    repeat (5) @(negedge clk);
    start = 1'b1; base_addr = 32'h99;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 300 && (n_valid - v0) < R + 1; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("d_busy_compute", busy, 1'b1);
    chk("d_read_compute", mem_read, 1'b0);
    start = 1'b1; base_addr = 32'h99;
    @(negedge clk);
    start = 1'b0;
    wait_done(t);
    check_reads("d", a0, 32'h30);
    check_results("d", 32'h30);

    // Reset during FETCH after 4 words, stray readdatavalid after release
    load(32'h50, 3);
    v0 = n_valid;
    do_start(32'h50);
    for (int i = 0; i < 300 && (n_valid - v0) < 4; i++) @(negedge clk);
    chk("e_words", (n_valid - v0) >= 4, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("e_busy", busy, 1'b0);
    chk("e_done", done, 1'b0);
    chk("e_read", mem_read, 1'b0);
    chk("e_addr", mem_address, 32'h0);
    chk("e_res", res_u, '0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    inj_gen++;
    repeat (4) @(negedge clk);
    chk("e_idle_busy", busy, 1'b0);
    chk("e_idle_read", mem_read, 1'b0);
    chk("e_idle_done", done, 1'b0);
    chk("e_idle_res", res_u, '0);
    load(32'h60, 3);
    a0 = acc_log.size();
    do_start(32'h60);
    wait_done(t);
    check_reads("e", a0, 32'h60);
    check_results("e", 32'h60);

    // All 0xFF: 8-bit accumulator wraps to 8; then restart from DONE
    load(32'h70, 2);
    do_start(32'h70);
    wait_done(t);
    for (int r = 0; r < R; r++) chk("f_acc8", res_8[r*8 +: 8], 8'd8);
    check_results("f", 32'h70);
    load(32'h40, 3);
    a0 = acc_log.size();
    do_start(32'h40);
    chk("f_done_drop", done, 1'b0);
    chk("f_busy", busy, 1'b1);
    chk("f_read", mem_read, 1'b1);
    chk("f_addr", mem_address, 32'h40);
    chk("f_addr_s", addr_s, 32'h40);
    chk("f_addr_8", addr_8, 32'h40);
    chk("f_busy_8", busy_8 & busy_s & rd_s & rd_8, 1'b1);
    wait_done(t);
    check_reads("f2", a0, 32'h40);
    check_results("f2", 32'h40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
